// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : muldiv_sequencer_if
//  Description : Decode-side bundle between the instruction decoder and the
//                multi-cycle MULT/DIV sequencer.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals (direction as seen by the sequencer, i.e. the slave modport)
//    start   in   issue strobe, decode holds an R-type instruction
//    func    in   R-type function field
//    rs_val  in   dividend / multiplicand
//    rt_val  in   divisor / multiplier
//    mf_req  in   MFHI/MFLO present in decode
//    hi      out  HI register (product high half / remainder)
//    lo      out  LO register (product low half / quotient)
//    busy    out  iteration or fix-up in progress
//    done    out  one-cycle pulse, hi/lo hold the new result
//    stall   out  hold PC and decode
//    div0    out  sticky divide-by-zero flag
// ============================================================================
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mf_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;
  logic             div0;

  // Decoder side
  modport master (
    output start, func, rs_val, rt_val, mf_req,
    input  hi, lo, busy, done, stall, div0
  );

  // Sequencer side
  modport slave (
    input  start, func, rs_val, rt_val, mf_req,
    output hi, lo, busy, done, stall, div0
  );

endinterface : muldiv_sequencer_if
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Multi-cycle controller and iterative engine for the MULT and
//                DIV R-type functions. Owns the HI/LO registers, runs one
//                shift-add (multiply) or restoring shift-subtract (divide)
//                step per cycle on operand magnitudes, then applies the sign
//                correction in a single fix-up cycle. Raises stall when a
//                HI/LO read or a second mult/div issue meets a busy engine.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk     in   system clock, rising edge
//    rst     in   asynchronous active-high reset, discards any operation
//    bus     --   muldiv_sequencer_if.slave (start/func/rs_val/rt_val/mf_req
//                 in; hi/lo/busy/done/stall/div0 out)
//
//  Parameters
//    WIDTH   operand width, HI/LO width and iteration count
//    CNT_W   iteration counter width, 2**CNT_W must exceed WIDTH
//
//  Build option
//    MULDIV_UNSIGNED_EN  when defined, MULTU (6'b011001) and DIVU (6'b011011)
//                        are accepted as well; they use the raw operands and
//                        the fix-up cycle leaves the result untouched.
// ============================================================================
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_sequencer_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
`ifdef MULDIV_UNSIGNED_EN
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
`endif

  // Counter value during the last iteration step
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                 state_q,  state_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  // Multiply: {partial product high, remaining multiplier bits}
  // Divide:   {partial remainder, dividend bits shifting into quotient}
  logic [2*WIDTH-1:0]     acc_q,    acc_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide)
  logic [WIDTH-1:0]       opnd_q,   opnd_d;
  logic                   is_div_q, is_div_d;
  // Sign of the product / quotient
  logic                   neg_q,    neg_d;
  // Sign of the dividend, which the remainder inherits
  logic                   rs_neg_q, rs_neg_d;
  logic [WIDTH-1:0]       hi_q,     hi_d;
  logic [WIDTH-1:0]       lo_q,     lo_d;
  logic                   div0_q,   div0_d;

  // --------------------------------------------------------------------------
  // Decode of the issued instruction
  // --------------------------------------------------------------------------
  logic is_mult;
  logic is_div;
  logic op_signed;

`ifdef MULDIV_UNSIGNED_EN
  assign is_mult   = (bus.func == FUNC_MULT) || (bus.func == FUNC_MULTU);
  assign is_div    = (bus.func == FUNC_DIV)  || (bus.func == FUNC_DIVU);
  // The unsigned variants are the odd function codes
  assign op_signed = ~bus.func[0];
`else
  assign is_mult   = (bus.func == FUNC_MULT);
  assign is_div    = (bus.func == FUNC_DIV);
  assign op_signed = 1'b1;
`endif

  logic             is_muldiv;
  logic             can_accept;
  logic             accept;
  logic             div_by_zero;
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  assign is_muldiv   = is_mult || is_div;
  assign can_accept  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept      = bus.start && is_muldiv && can_accept;
  assign div_by_zero = is_div && (bus.rt_val == '0);

  assign rs_neg = op_signed && bus.rs_val[WIDTH-1];
  assign rt_neg = op_signed && bus.rt_val[WIDTH-1];
  // The most negative value maps onto itself, which is the correct unsigned
  // magnitude, so no extra bit is needed.
  assign rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
  assign rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;

  // --------------------------------------------------------------------------
  // Datapath: one iteration step of each algorithm
  // --------------------------------------------------------------------------
  // Multiply: conditionally add the multiplicand into the high half, then
  // shift the whole accumulator right; the carry becomes the new MSB.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: shift the next dividend bit into the remainder, subtract the
  // divisor when it fits and record a quotient bit. When the subtraction is
  // taken the difference is below the divisor, so WIDTH bits hold it.
  logic [WIDTH:0]       div_shift;
  logic                 div_fits;
  logic [WIDTH-1:0]     div_rem_sub;
  logic [2*WIDTH-1:0]   div_step;

  assign div_shift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_fits    = (div_shift >= {1'b0, opnd_q});
  assign div_rem_sub = div_shift[WIDTH-1:0] - opnd_q;
  assign div_step    = div_fits ? {div_rem_sub,          acc_q[WIDTH-2:0], 1'b1}
                                : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // --------------------------------------------------------------------------
  // Datapath: sign correction applied in the fix-up cycle
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_q    ? -acc_q                    : acc_q;
  assign quo_fix  = neg_q    ? -acc_q[WIDTH-1:0]         : acc_q[WIDTH-1:0];
  assign rem_fix  = rs_neg_q ? -acc_q[2*WIDTH-1:WIDTH]   : acc_q[2*WIDTH-1:WIDTH];

  // --------------------------------------------------------------------------
  // Next-state and register-update logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rs_neg_d = rs_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div0_d   = div0_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE lasts a single cycle unless a new operation is taken
        state_d = ST_IDLE;
        if (accept) begin
          div0_d   = 1'b0;
          cnt_d    = '0;
          is_div_d = is_div;
          neg_d    = rs_neg ^ rt_neg;
          rs_neg_d = rs_neg;
          if (div_by_zero) begin
            // Result is defined directly, no iteration needed
            hi_d    = bus.rs_val;
            lo_d    = '1;
            div0_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            // Multiplier or dividend sits in the low half and is consumed
            // one bit per step from the LSB (multiply) or MSB (divide).
            opnd_d  = is_div ? rt_mag : rs_mag;
            acc_d   = {{WIDTH{1'b0}}, (is_div ? rs_mag : rt_mag)};
            state_d = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIXUP;
        end
      end

      ST_FIXUP: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rs_neg_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rs_neg_q <= rs_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div0_q   <= div0_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  logic busy;

  assign busy     = (state_q == ST_BUSY) || (state_q == ST_FIXUP);

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy;
  assign bus.done = (state_q == ST_DONE);
  assign bus.div0 = div0_q;
  // In DONE the result is already in hi/lo and a new issue can be taken,
  // so only BUSY/FIXUP hold the pipeline.
  assign bus.stall = busy && (bus.mf_req || (bus.start && is_muldiv));

endmodule : muldiv_sequencer
`default_nettype wire
